// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared widths, types and helpers for the FPU 3x3 convolution stage.
//   PIX_W / COEF_W / ACC_W : pixel, coefficient and accumulator widths
//   ROWS / OUT_ROWS        : pixels per input column and per output beat
//   pixel_t, coef_t, acc_t, kernel_t, state_t
//   norm_clamp()           : round-half-up shift and clamp to pixel range
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int PIX_W    = 8;
    localparam int ROWS     = 10;
    localparam int OUT_ROWS = ROWS - 2;
    localparam int COEF_W   = 8;
    localparam int ACC_W    = 20;
    localparam int NUM_COEF = 9;
    localparam int PIX_MAX  = (1 << PIX_W) - 1;

    typedef logic        [PIX_W-1:0]  pixel_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef coef_t                    kernel_t [3][3];

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Adds half an LSB of the shifted result before the arithmetic shift so
    // that ties round upwards; a zero shift leaves the sum untouched. The
    // bias cannot overflow ACC_W because the largest magnitude sum is well
    // below 2^(ACC_W-1) - 2^14.
    function automatic pixel_t norm_clamp(input acc_t sum, input logic [3:0] shift);
        acc_t bias;
        acc_t shifted;
        pixel_t result;
        bias = '0;
        if (shift != 4'd0) begin
            bias = acc_t'(1) << (shift - 4'd1);
        end
        shifted = (sum + bias) >>> shift;
        if (shifted[ACC_W-1]) begin
            result = '0;
        end else if (shifted > acc_t'(PIX_MAX)) begin
            result = pixel_t'(PIX_MAX);
        end else begin
            result = shifted[PIX_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/fpu_conv_lane.sv
// ---------------------------------------------------------------------------
// fpu_conv_lane
// One output pixel of the 3x3 convolution, three register stages deep.
//   clk, rst      : clock, asynchronous active-high reset
//   s1_en_i       : beat accepted this cycle (load products and shift)
//   s2_en_i       : stage-1 contents valid (load sum)
//   s3_en_i       : stage-2 contents valid (load output pixel)
//   win_i[r][c]   : pixel at row offset r of column c
//   kernel_i[r][c]: signed coefficient paired with win_i[r][c]
//   shift_i       : normalisation right-shift for this beat
//   pix_o         : registered, rounded and clamped output pixel
// ---------------------------------------------------------------------------
module fpu_conv_lane
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       s1_en_i,
    input  logic       s2_en_i,
    input  logic       s3_en_i,
    input  pixel_t     win_i [3][3],
    input  kernel_t    kernel_i,
    input  logic [3:0] shift_i,
    output pixel_t     pix_o
);

    acc_t       prod_d [3][3];
    acc_t       prod_q [3][3];
    logic [3:0] shift_s1_q;
    logic [3:0] shift_s2_q;
    acc_t       sum_d;
    acc_t       sum_q;
    pixel_t     pix_q;

    // Pixels are unsigned, so a zero bit is prepended before the signed
    // multiply; each product fits comfortably in the accumulator width.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod_d[r][c] = acc_t'($signed({1'b0, win_i[r][c]})) * acc_t'(kernel_i[r][c]);
            end
        end
    end

    // Stage 1: latch all nine products and the shift that travels with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod_q[r][c] <= '0;
                end
            end
            shift_s1_q <= '0;
        end else if (s1_en_i) begin
            prod_q     <= prod_d;
            shift_s1_q <= shift_i;
        end
    end

    // Adder tree over the latched products.
    always_comb begin
        sum_d = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum_d = sum_d + prod_q[r][c];
            end
        end
    end

    // Stage 2: latch the sum alongside its shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q      <= '0;
            shift_s2_q <= '0;
        end else if (s2_en_i) begin
            sum_q      <= sum_d;
            shift_s2_q <= shift_s1_q;
        end
    end

    // Stage 3: normalised pixel; holds its value between valid beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
        end else if (s3_en_i) begin
            pix_q <= norm_clamp(sum_q, shift_s2_q);
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/fpu_conv_stage.sv
// ---------------------------------------------------------------------------
// fpu_conv_stage
// Pipelined 3x3 convolution engine fed by the FPU column buffers.
//   clk, rst           : clock, asynchronous active-high reset
//   kernel_wr/idx/data : serial coefficient load, idx 0..8 row-major k[r][c]
//   kernel_clear       : discard the loaded kernel and return to LOAD
//   norm_shift         : per-beat right-shift, sampled with in_valid
//   kernel_ready       : high while the engine is in RUN
//   in_valid, col0..2  : input beat of three ROWS-pixel columns
//   out_valid, pix_out : OUT_ROWS filtered pixels, three cycles later
// ---------------------------------------------------------------------------
module fpu_conv_stage
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              kernel_wr,
    input  logic [3:0]        kernel_idx,
    input  logic [COEF_W-1:0] kernel_data,
    input  logic              kernel_clear,
    input  logic [3:0]        norm_shift,
    output logic              kernel_ready,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  col0 [ROWS],
    input  logic [PIX_W-1:0]  col1 [ROWS],
    input  logic [PIX_W-1:0]  col2 [ROWS],
    output logic              out_valid,
    output logic [PIX_W-1:0]  pix_out [OUT_ROWS]
);

    state_t              state_q;
    logic [NUM_COEF-1:0] mask_q;
    coef_t               coef_q [NUM_COEF];
    logic                kernel_ready_q;
    logic                accept;
    logic                s1_valid_q;
    logic                s2_valid_q;
    logic                s3_valid_q;
    kernel_t             kernel;

    // Kernel load FSM. The RUN transition looks at the registered mask, so
    // it happens one edge after the final coefficient lands. A clear always
    // beats a simultaneous write. Coefficients survive a clear, but the mask
    // forces every index to be written again before streaming resumes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= LOAD;
            mask_q         <= '0;
            kernel_ready_q <= 1'b0;
            for (int k = 0; k < NUM_COEF; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (kernel_clear) begin
                        mask_q <= '0;
                    end else begin
                        if (&mask_q) begin
                            state_q        <= RUN;
                            kernel_ready_q <= 1'b1;
                        end
                        if (kernel_wr && (kernel_idx < 4'(NUM_COEF))) begin
                            coef_q[kernel_idx] <= coef_t'(kernel_data);
                            mask_q[kernel_idx] <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (kernel_clear) begin
                        state_q        <= LOAD;
                        mask_q         <= '0;
                        kernel_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= LOAD;
                    kernel_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign kernel_ready = kernel_ready_q;
    assign accept       = in_valid && (state_q == RUN);

    // Valid shift chain. Products are captured at acceptance, so beats in
    // flight drain correctly even if the kernel is cleared behind them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
        end
    end

    assign out_valid = s3_valid_q;

    // Present the flat coefficient store as a row-major 3x3 kernel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                kernel[r][c] = coef_q[3*r + c];
            end
        end
    end

    for (genvar i = 0; i < OUT_ROWS; i++) begin : g_lane
        pixel_t win [3][3];

        // Output i sees rows i..i+2 of each column; column c pairs with k[r][c].
        always_comb begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] = col0[i + r];
                win[r][1] = col1[i + r];
                win[r][2] = col2[i + r];
            end
        end

        fpu_conv_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .s1_en_i  (accept),
            .s2_en_i  (s1_valid_q),
            .s3_en_i  (s2_valid_q),
            .win_i    (win),
            .kernel_i (kernel),
            .shift_i  (norm_shift),
            .pix_o    (pix_out[i])
        );
    end

endmodule

// File: tb/tb_fpu_conv_stage.sv
// ---------------------------------------------------------------------------
// tb_fpu_conv_stage
// Directed and randomized stimulus for fpu_conv_stage, checked every cycle
// against a behavioural model of the kernel loader and the convolution.
// ---------------------------------------------------------------------------
module tb_fpu_conv_stage;

    typedef struct packed {
        logic        valid;
        logic [63:0] pix;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       kernel_wr;
    logic [3:0] kernel_idx;
    logic [7:0] kernel_data;
    logic       kernel_clear;
    logic [3:0] norm_shift;
    logic       kernel_ready;
    logic       in_valid;
    logic [7:0] col0 [10];
    logic [7:0] col1 [10];
    logic [7:0] col2 [10];
    logic       out_valid;
    logic [7:0] pix_out [8];

    int checks = 0;
    int passes = 0;

    // Reference model state
    int          mK [9];
    logic [8:0]  mMask;
    bit          mRun;
    logic [63:0] lastPix;
    beat_t       hist [$];
    int          kload [9];

    fpu_conv_stage dut (
        .clk          (clk),
        .rst          (rst),
        .kernel_wr    (kernel_wr),
        .kernel_idx   (kernel_idx),
        .kernel_data  (kernel_data),
        .kernel_clear (kernel_clear),
        .norm_shift   (norm_shift),
        .kernel_ready (kernel_ready),
        .in_valid     (in_valid),
        .col0         (col0),
        .col1         (col1),
        .col2         (col2),
        .out_valid    (out_valid),
        .pix_out      (pix_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Round half up via floor division, then clamp to 0..255.
    function automatic int refPix(input int sum, input int sh);
        int num;
        int d;
        int q;
        if (sh == 0) begin
            q = sum;
        end else begin
            d   = 1 << sh;
            num = sum + d / 2;
            q   = num / d;
            if (num < 0 && (num % d) != 0) q = q - 1;
        end
        if (q < 0) q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    function automatic logic [63:0] expectedBeat();
        logic [63:0] res;
        int sum;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            sum = 0;
            for (int r = 0; r < 3; r++) begin
                sum += mK[3*r + 0] * int'(col0[i + r]);
                sum += mK[3*r + 1] * int'(col1[i + r]);
                sum += mK[3*r + 2] * int'(col2[i + r]);
            end
            res[8*i +: 8] = 8'(refPix(sum, int'(norm_shift)));
        end
        return res;
    endfunction

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkOutput(input logic expValid);
        logic [63:0] got;
        for (int i = 0; i < 8; i++) got[8*i +: 8] = pix_out[i];
        checkEq("out_valid", 64'(out_valid), 64'(expValid));
        checkEq("pix_out", got, lastPix);
        checkEq("kernel_ready", 64'(kernel_ready), 64'(mRun));
    endtask

    task automatic modelReset();
        beat_t idleBeat;
        idleBeat = '0;
        for (int k = 0; k < 9; k++) mK[k] = 0;
        mMask   = '0;
        mRun    = 1'b0;
        lastPix = '0;
        hist.delete();
        hist.push_back(idleBeat);
        hist.push_back(idleBeat);
    endtask

    // One clock: the model consumes the inputs the DUT just captured.
    task automatic tick();
        beat_t b;
        beat_t e;
        @(posedge clk);
        #1;
        b.valid = in_valid && mRun;
        b.pix   = b.valid ? expectedBeat() : 64'd0;
        hist.push_back(b);
        if (!mRun) begin
            if (kernel_clear) begin
                mMask = '0;
            end else begin
                if (mMask == 9'h1FF) mRun = 1'b1;
                if (kernel_wr && kernel_idx < 4'd9) begin
                    mK[kernel_idx]    = int'($signed(kernel_data));
                    mMask[kernel_idx] = 1'b1;
                end
            end
        end else if (kernel_clear) begin
            mRun  = 1'b0;
            mMask = '0;
        end
        e = hist.pop_front();
        if (e.valid) lastPix = e.pix;
        checkOutput(e.valid);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic doReset();
        in_valid     = 1'b0;
        kernel_wr    = 1'b0;
        kernel_clear = 1'b0;
        rst          = 1'b1;
        #1;
        modelReset();
        checkOutput(1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic v, input int sh);
        in_valid   = v;
        norm_shift = 4'(sh);
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic writeCoef(input int idx, input int val);
        kernel_wr   = 1'b1;
        kernel_idx  = 4'(idx);
        kernel_data = 8'(val);
        tick();
        kernel_wr   = 1'b0;
    endtask

    task automatic loadKernel();
        for (int k = 0; k < 9; k++) writeCoef(k, kload[k]);
    endtask

    task automatic clearKernel();
        kernel_clear = 1'b1;
        tick();
        kernel_clear = 1'b0;
    endtask

    task automatic randCols();
        for (int j = 0; j < 10; j++) begin
            col0[j] = 8'($urandom);
            col1[j] = 8'($urandom);
            col2[j] = 8'($urandom);
        end
    endtask

    task automatic fillCols(input int v);
        for (int j = 0; j < 10; j++) begin
            col0[j] = 8'(v);
            col1[j] = 8'(v);
            col2[j] = 8'(v);
        end
    endtask

    task automatic randKernel();
        for (int k = 0; k < 9; k++) kload[k] = $urandom_range(0, 255) - 128;
    endtask

    initial begin
        rst          = 1'b1;
        kernel_wr    = 1'b0;
        kernel_clear = 1'b0;
        in_valid     = 1'b0;
        kernel_idx   = '0;
        kernel_data  = '0;
        norm_shift   = '0;
        fillCols(0);
        doReset();

        // Beats offered while still loading must be ignored.
        for (int n = 0; n < 3; n++) begin
            randCols();
            applyStimulus(1'b1, 0);
        end
        idle(4);

        // Identity kernel: output i is col1[i+1] = 10*(i+1).
        for (int k = 0; k < 9; k++) kload[k] = 0;
        kload[4] = 1;
        loadKernel();
        idle(1);
        randCols();
        for (int j = 0; j < 10; j++) col1[j] = 8'(10 * j);
        applyStimulus(1'b1, 0);
        idle(3);

        // Box kernel: 720 >> 3 = 90, then 9*255 clamps to 255.
        clearKernel();
        for (int k = 0; k < 9; k++) kload[k] = 1;
        loadKernel();
        idle(1);
        fillCols(80);
        applyStimulus(1'b1, 3);
        fillCols(255);
        applyStimulus(1'b1, 0);
        idle(3);

        // Negative centre tap clamps to 0; out-of-range index and RUN writes ignored.
        clearKernel();
        for (int k = 0; k < 9; k++) kload[k] = 0;
        kload[4] = -128;
        writeCoef(9, 127);
        loadKernel();
        idle(1);
        writeCoef(4, 5);
        writeCoef(9, 3);
        fillCols(10);
        applyStimulus(1'b1, 0);
        randCols();
        applyStimulus(1'b1, 2);
        idle(3);

        // Clear colliding with the final write: the write is dropped, stay in LOAD.
        clearKernel();
        randKernel();
        for (int k = 0; k < 8; k++) writeCoef(k, kload[k]);
        kernel_clear = 1'b1;
        kernel_wr    = 1'b1;
        kernel_idx   = 4'd8;
        kernel_data  = 8'(kload[8]);
        tick();
        kernel_clear = 1'b0;
        kernel_wr    = 1'b0;
        idle(2);

        // Full reload with an overwrite of idx 0, then stream 1,1,0,1 and clear.
        writeCoef(0, $urandom_range(0, 255));
        randKernel();
        loadKernel();
        idle(1);
        randCols(); applyStimulus(1'b1, $urandom_range(0, 15));
        randCols(); applyStimulus(1'b1, $urandom_range(0, 15));
        randCols(); applyStimulus(1'b0, 0);
        randCols(); applyStimulus(1'b1, $urandom_range(0, 15));
        clearKernel();
        idle(4);

        // Randomized stream with a random kernel and random gaps.
        randKernel();
        loadKernel();
        idle(1);
        for (int n = 0; n < 40; n++) begin
            randCols();
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end
        idle(3);

        // Reset with two beats in flight: nothing may emerge afterwards.
        randCols(); applyStimulus(1'b1, 2);
        randCols(); applyStimulus(1'b1, 5);
        doReset();
        idle(5);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
